// File: rtl/motor_cmd_spi_rx_if.sv
// Purpose : bundles the SPI slave inputs and motor command outputs of motor_cmd_spi_rx.
// Latency : n/a (signal bundle only).
// Backpressure: none; SPI is push-only and the motor outputs are levels/pulses.
// Ports   : sclk/cs_n/mosi from the MCU; motor1/2 sign+period, cmd_valid, frame_err, timeout to the motor stage.
interface motor_cmd_spi_rx_if;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       motor1_sign;
   logic [6:0] motor1_period;
   logic       motor2_sign;
   logic [6:0] motor2_period;
   logic       cmd_valid;
   logic       frame_err;
   logic       timeout;

   // MCU side drives SPI and observes the command outputs.
   modport master (
      output sclk, cs_n, mosi,
      input  motor1_sign, motor1_period, motor2_sign, motor2_period,
      input  cmd_valid, frame_err, timeout
   );

   // Receiver side.
   modport slave (
      input  sclk, cs_n, mosi,
      output motor1_sign, motor1_period, motor2_sign, motor2_period,
      output cmd_valid, frame_err, timeout
   );
endinterface

// File: rtl/motor_cmd_spi_rx.sv
// Purpose : SPI mode-0 slave receiving 16-bit motor commands, with a stop-on-silence watchdog.
// Latency : 3 clk edges from raw cs_n rise to loaded outputs / cmd_valid pulse.
// Backpressure: none; every good frame loads immediately, bad frames pulse frame_err.
// Ports   : i_clk, i_reset (sync, active high); io_cmd (slave modport) carries SPI in and motor outputs.
module motor_cmd_spi_rx #(
   parameter int TIMEOUT_CYCLES = 4800000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   motor_cmd_spi_rx_if.slave  io_cmd
);

   typedef enum logic {ST_IDLE, ST_RECV} state_t;

   localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_state_nxt;

   // Synchronizers plus one extra stage on sclk/cs_n for edge detection.
   logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic        r_cs_s1, r_cs_s2, r_cs_d;
   logic        r_mosi_s1, r_mosi_s2;

   // r_live marks that r_cs_s1 holds a real sample rather than its reset value;
   // r_armed then requires a genuine high cs_n before any fall is accepted, so a
   // cs_n held low across reset cannot start a frame.
   logic        r_live, r_armed;

   logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic [15:0] r_shift, w_shift_nxt;
   logic [23:0] r_wd, w_wd_nxt;
   logic        r_m1_sign, w_m1_sign_nxt;
   logic [6:0]  r_m1_per, w_m1_per_nxt;
   logic        r_m2_sign, w_m2_sign_nxt;
   logic [6:0]  r_m2_per, w_m2_per_nxt;
   logic        r_cmd_valid, w_cmd_valid_nxt;
   logic        r_frame_err, w_frame_err_nxt;
   logic        r_timeout, w_timeout_nxt;

   logic        w_sclk_rise, w_cs_fall, w_cs_rise;

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
   assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
   assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_d  <= 1'b0;
         r_cs_s1   <= 1'b1;
         r_cs_s2   <= 1'b1;
         r_cs_d    <= 1'b1;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
         r_live    <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_sclk_s1 <= io_cmd.sclk;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_d  <= r_sclk_s2;
         r_cs_s1   <= io_cmd.cs_n;
         r_cs_s2   <= r_cs_s1;
         r_cs_d    <= r_cs_s2;
         r_mosi_s1 <= io_cmd.mosi;
         r_mosi_s2 <= r_mosi_s1;
         r_live    <= 1'b1;
         r_armed   <= r_armed | (r_live & r_cs_s1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 5'd0;
         r_shift     <= 16'd0;
         r_wd        <= 24'd0;
         r_m1_sign   <= 1'b0;
         r_m1_per    <= 7'd0;
         r_m2_sign   <= 1'b0;
         r_m2_per    <= 7'd0;
         r_cmd_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_wd        <= w_wd_nxt;
         r_m1_sign   <= w_m1_sign_nxt;
         r_m1_per    <= w_m1_per_nxt;
         r_m2_sign   <= w_m2_sign_nxt;
         r_m2_per    <= w_m2_per_nxt;
         r_cmd_valid <= w_cmd_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_wd_nxt        = r_wd;
      w_m1_sign_nxt   = r_m1_sign;
      w_m1_per_nxt    = r_m1_per;
      w_m2_sign_nxt   = r_m2_sign;
      w_m2_per_nxt    = r_m2_per;
      w_cmd_valid_nxt = 1'b0;
      w_frame_err_nxt = 1'b0;
      w_timeout_nxt   = r_timeout;

      // Watchdog: counts until expiry, then holds with the motors stopped.
      if (!r_timeout) begin
         if (r_wd == WD_LAST) begin
            w_timeout_nxt = 1'b1;
            w_m1_sign_nxt = 1'b0;
            w_m1_per_nxt  = 7'd0;
            w_m2_sign_nxt = 1'b0;
            w_m2_per_nxt  = 7'd0;
         end else begin
            w_wd_nxt = r_wd + 24'd1;
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall && r_armed) begin
               w_state_nxt   = ST_RECV;
               w_bit_cnt_nxt = 5'd0;
               w_shift_nxt   = 16'd0;
            end
         end
         ST_RECV: begin
            // cs_n rise wins over a coincident sclk edge.
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               if (r_bit_cnt == 5'd16) begin
                  // Good frame overrides a coincident watchdog expiry.
                  w_m1_sign_nxt   = r_shift[15];
                  w_m1_per_nxt    = r_shift[14:8];
                  w_m2_sign_nxt   = r_shift[7];
                  w_m2_per_nxt    = r_shift[6:0];
                  w_cmd_valid_nxt = 1'b1;
                  w_timeout_nxt   = 1'b0;
                  w_wd_nxt        = 24'd0;
               end else begin
                  w_frame_err_nxt = 1'b1;
               end
            end else if (w_sclk_rise) begin
               w_shift_nxt   = {r_shift[14:0], r_mosi_s2};
               w_bit_cnt_nxt = (r_bit_cnt == 5'd17) ? 5'd17 : r_bit_cnt + 5'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign io_cmd.motor1_sign   = r_m1_sign;
   assign io_cmd.motor1_period = r_m1_per;
   assign io_cmd.motor2_sign   = r_m2_sign;
   assign io_cmd.motor2_period = r_m2_per;
   assign io_cmd.cmd_valid     = r_cmd_valid;
   assign io_cmd.frame_err     = r_frame_err;
   assign io_cmd.timeout       = r_timeout;

endmodule

// File: doc/motor_cmd_spi_rx.md
MOTOR_CMD_SPI_RX -- requirements
Module: motor_cmd_spi_rx

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4800000 (100 ms at 48 MHz), clk cycles without a valid frame before the motors are commanded to stop.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sclk  input  1  SPI clock from the MCU, asynchronous to clk, mode 0.
REQ-005 cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-006 mosi  input  1  SPI data, MSB first, asynchronous.
REQ-007 motor1_sign  output  1  motor 1 direction.
REQ-008 motor1_period  output  7  motor 1 PWM period; 0 = stop.
REQ-009 motor2_sign  output  1  motor 2 direction.
REQ-010 motor2_period  output  7  motor 2 PWM period; 0 = stop.
REQ-011 cmd_valid  output  1  one-cycle pulse when the outputs are loaded from a good frame.
REQ-012 frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-013 timeout  output  1  level; high while in watchdog stop.

Function
REQ-014 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer, and a third flop SHALL hold the previous synchronized sclk and cs_n values for edge detection.
REQ-015 States SHALL be IDLE (cs_n high) and RECV (cs_n low); a synchronized cs_n fall SHALL move IDLE->RECV and clear the bit counter and the shift register.
REQ-016 In RECV, each synchronized sclk rising edge SHALL shift synchronized mosi into the LSB of a 16-bit shift register and increment a 5-bit bit counter that saturates at 17.
REQ-017 A synchronized cs_n rise SHALL move RECV->IDLE; in the same cycle, if the bit count equals exactly 16, the frame is good; otherwise the frame is bad.
REQ-018 A good frame maps bits as follows: bit15 = motor1_sign, bits14:8 = motor1_period, bit7 = motor2_sign, bits6:0 = motor2_period.
REQ-019 On a good frame, all four motor outputs SHALL be loaded together and cmd_valid SHALL pulse high for exactly one cycle.
REQ-020 On a bad frame (count <16 or >16), the outputs SHALL be held, frame_err SHALL pulse for one cycle, and the watchdog SHALL NOT be cleared.
REQ-021 Latency SHALL be 3 clk rising edges from the raw cs_n rise to the outputs and cmd_valid (2 sync + 1 register), assuming setup is met.
REQ-022 The outputs SHALL change only on a good frame, on a watchdog expiry or on reset, and never mid-frame.
REQ-023 If an sclk rising edge and a cs_n rise are detected in the same cycle, the cs_n rise SHALL take precedence and that sclk edge SHALL be ignored.
REQ-024 sclk edges SHALL be ignored in IDLE.
REQ-025 A cs_n fall while in RECV SHALL be impossible; a glitch of fewer than 2 clk cycles MAY be missed by the synchronizer.
REQ-026 The watchdog counter (24 bits) SHALL increment every cycle and clear to 0 on a good frame.
REQ-027 When the watchdog counter reaches TIMEOUT_CYCLES-1, the next cycle SHALL force both periods and both signs to 0 and set timeout to 1; the counter SHALL then hold.
REQ-028 timeout SHALL stay high until a good frame, which clears it in the same cycle the new values load.
REQ-029 If a good frame and watchdog expiry coincide, the good frame SHALL win: its values load, timeout stays 0 and the counter clears.

Reset
REQ-030 While reset is high: state = IDLE; bit counter, shift register and watchdog = 0; all motor outputs = 0; cmd_valid = frame_err = timeout = 0; synchronizer flops = cs_n 1, sclk 0, mosi 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no frame_err; after release, the block SHALL wait for a fresh cs_n fall, so a cs_n that is already low gives no frame until it cycles high then low.

Verification
REQ-032 Send 16-bit frame 0x8A15 (sclk at clk/8) -> 3 cycles after the cs_n rise: motor1_sign=1, motor1_period=0x0A, motor2_sign=0, motor2_period=0x15; cmd_valid high for 1 cycle.
REQ-033 Send a 15-bit frame, then a 17-bit frame -> frame_err pulses twice; outputs keep their previous values; cmd_valid stays 0.
REQ-034 With TIMEOUT_CYCLES=100, send no frame after 0x8A15 -> 100 cycles after its cmd_valid, all periods and signs = 0 and timeout=1; then send 0x0505 -> periods=5, timeout=0.
REQ-035 Assert reset for 1 cycle after 8 bits of a frame -> outputs 0; completing that frame gives no cmd_valid and no frame_err; the next full frame loads normally.
REQ-036 Time a good frame's cs_n rise so its detection falls in the watchdog's final cycle -> the new values load and timeout stays 0.
REQ-037 Toggle sclk with cs_n high, then send 0x7F7F -> no shifts in IDLE; periods=127, signs=0.
